sync_updown_counter: RTL and testbench
======================================

Name: sync_updown_counter

Overview:
Parametrised synchronous modulo-N up/down counter, the successor to the fixed 4-bit DFF up counter. Adds run-time direction, enable, parallel load, synchronous clear and a wrap/saturate mode. An internal prescaler replaces the external divided clock, so the whole block runs on one clock. Outputs support cascading and status: terminal count, a wrap pulse and a sticky overflow flag. Intended for lab top-levels that drive LEDR/HEX from switch and key inputs.

Parameters:
WIDTH, 4, counter width in bits; 1..32.
MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2..2**WIDTH. Elaboration error outside this range.
DIV_BITS, 0, prescaler width. The count advances once every 2**DIV_BITS enabled cycles; 0 means every cycle. Use 24 on hardware at 50 MHz.

Ports:
clk  in  1  single clock; all state changes on posedge.
reset  in  1  synchronous, active-low. reset=0 at a posedge initialises all state.
en  in  1  count enable; also gates the prescaler.
up  in  1  direction: 1 counts up, 0 counts down.
sat  in  1  mode: 1 saturates at the end of range, 0 wraps.
sclr  in  1  synchronous clear to 0.
load  in  1  synchronous parallel load.
d  in  WIDTH  load value.
q  out  WIDTH  registered count.
tc  out  1  combinational terminal count, for cascading.
wrap  out  1  registered one-cycle pulse on a wrap event.
ovf  out  1  registered sticky flag set on a wrap or a saturation attempt.

Behaviour:
- Reset (reset=0 at posedge): q=0, prescaler=0, wrap=0, ovf=0. Reset overrides all other inputs, including mid-count and mid-prescale.
- Priority per posedge: reset > sclr > load > count step.
- sclr=1: q=0, prescaler=0, wrap=0, ovf=0.
- load=1: q=d, or q=MODULUS-1 if d>=MODULUS (clamp). Prescaler=0, wrap=0, ovf=0. load has priority over en.
- tick: prescaler==2**DIV_BITS-1 && en. With DIV_BITS=0, tick=en.
- Prescaler: increments when en=1 and wraps to 0 on tick; holds when en=0.
- Count step (tick=1, no sclr/load):
  - up=1, q<MODULUS-1: q+1.
  - up=1, q==MODULUS-1: sat=0 gives q=0, wrap=1, ovf=1. sat=1 gives q held, wrap=0, ovf=1.
  - up=0, q>0: q-1.
  - up=0, q==0: sat=0 gives q=MODULUS-1, wrap=1, ovf=1. sat=1 gives q held, wrap=0, ovf=1.
- No tick: q holds; wrap=0; ovf holds.
- wrap is high for exactly the cycle in which q first shows the wrapped value. It is never high for two consecutive cycles unless a tick occurs every cycle.
- tc = en && (up ? q==MODULUS-1 : q==0). Combinational and independent of the prescaler and of sat. Cascade rule: drive the next stage's en from tc && tick-equivalent; in practice use DIV_BITS=0 for the upper stages.
- Direction change takes effect at the next tick; no extra latency.
- Latency: inputs sampled at posedge N are reflected on q/wrap/ovf after posedge N.
- Arithmetic: compare and add in WIDTH+1 bits, so MODULUS=2**WIDTH does not overflow the constant.

Decomposition:
- Package counter_pkg: function clamp_mod(value, modulus); localparam conventions for MODULUS range checks.
- Sub-module tick_gen (parameter DIV_BITS; ports clk, reset, en, clr, tick). The counter instantiates it with clr = sclr | load.
- All counter next-state logic lives in one always_comb; all registers in one always_ff.

Test Plan:
- Reset mid-count: WIDTH=4, MODULUS=10, DIV_BITS=0, en=1, up=1. Count to 6, then reset=0 for 1 cycle -> q=0, ovf=0, wrap=0. The next cycle with reset=1 gives q=1.
- Up wrap: MODULUS=10, up=1, sat=0, en=1 from q=0 -> q steps 0..9,0. wrap=1 only in the cycle q returns to 0; ovf=1 from then on; tc=1 while q=9.
- Down saturate: sat=1, up=0, load d=2, then en=1 -> q=2,1,0,0,0. ovf=1 from the first held cycle; wrap never asserts; tc=1 while q=0.
- Load clamp and priority: MODULUS=10, load=1 with d=13 and en=1 -> q=9 and ovf cleared. sclr and load both 1 -> q=0.
- Prescaler: DIV_BITS=2, en=1, up=1 -> q increments every 4th cycle. Dropping en for 3 cycles stretches the interval by exactly 3. load resets the prescaler phase.
- Full-range default: WIDTH=4, MODULUS=16, up=0 from q=0, sat=0 -> q=15 and wrap=1. Then 15 more ticks -> q=0 with tc=1.

Source files
------------

// File: rtl/sync_updown_counter_pkg.sv
// Shared helpers and limits for the modulo-N up/down counter.
package counter_pkg;

  localparam int MIN_WIDTH   = 1;
  localparam int MAX_WIDTH   = 32;
  localparam int MIN_MODULUS = 2;

  // Load values at or above the modulus clamp to the last legal count.
  function automatic logic [32:0] clamp_mod(input logic [32:0] value,
                                            input logic [32:0] modulus);
    return (value >= modulus) ? (modulus - 33'd1) : value;
  endfunction

endpackage

// File: rtl/sync_updown_counter_tick_gen.sv
// Prescaler: emits a count tick once every 2**DIV_BITS enabled cycles.
module tick_gen #(
  parameter int DIV_BITS = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (DIV_BITS == 0) begin : g_direct
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, clr};
    assign tick = en;
  end else begin : g_div
    logic [DIV_BITS-1:0] phase;

    assign tick = en && (phase == {DIV_BITS{1'b1}});

    // The phase wraps naturally at all-ones, which is exactly the tick cycle.
    always_ff @(posedge clk) begin
      if (!reset) begin
        phase <= '0;
      end else if (clr) begin
        phase <= '0;
      end else if (en) begin
        phase <= phase + {{(DIV_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate mode, prescaler
// and cascade/status outputs, all on a single clock.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int                WIDTH    = 4,
  parameter longint unsigned   MODULUS  = 64'd1 << WIDTH,
  parameter int                DIV_BITS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam longint unsigned MOD_LIMIT = 64'd1 << WIDTH;

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("sync_updown_counter: WIDTH out of range");
  end
  if (MODULUS < MIN_MODULUS || MODULUS > MOD_LIMIT) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS out of range");
  end

  // Comparisons run in WIDTH+1 bits so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 64'd1);

  logic             tick;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             ovf_next;
  logic [32:0]      load_val;

  tick_gen #(.DIV_BITS(DIV_BITS)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (sclr | load),
    .tick  (tick)
  );

  assign q_ext    = {1'b0, q};
  assign load_val = clamp_mod(33'(d), 33'(MODULUS));
  assign tc       = en && (up ? (q_ext == TOP) : (q == '0));

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    ovf_next  = ovf;
    if (sclr) begin
      q_next   = '0;
      ovf_next = 1'b0;
    end else if (load) begin
      q_next   = load_val[WIDTH-1:0];
      ovf_next = 1'b0;
    end else if (tick) begin
      if (up) begin
        if (q_ext < TOP) begin
          q_next = q + WIDTH'(1);
        end else begin
          ovf_next = 1'b1;
          if (!sat) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end
        end
      end else begin
        if (q != '0) begin
          q_next = q - WIDTH'(1);
        end else begin
          ovf_next = 1'b1;
          if (!sat) begin
            q_next    = TOP[WIDTH-1:0];
            wrap_next = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: three instances (MOD10, MOD10 with /4
// prescaler, full-range MOD16) driven from shared inputs.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, up = 1'b0, sat = 1'b0, sclr = 1'b0, load = 1'b0;
  logic [3:0] d = '0;

  logic [3:0] q_a, q_p, q_f;
  logic       tc_a, tc_p, tc_f, wrap_a, wrap_p, wrap_f, ovf_a, ovf_p, ovf_f;

  int checks = 0;
  int errors = 0;

  // {sel[1:0], q[3:0], wrap, ovf, tc}
  logic [8:0] exp_q[$];

  localparam logic [1:0] SEL_A = 2'd0, SEL_P = 2'd1, SEL_F = 2'd2;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .DIV_BITS(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .sclr(sclr),
    .load(load), .d(d), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a));

  sync_updown_counter #(.WIDTH(4), .MODULUS(64'd10), .DIV_BITS(2)) dut_p (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .sclr(sclr),
    .load(load), .d(d), .q(q_p), .tc(tc_p), .wrap(wrap_p), .ovf(ovf_p));

  sync_updown_counter #(.WIDTH(4), .DIV_BITS(0)) dut_f (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .sclr(sclr),
    .load(load), .d(d), .q(q_f), .tc(tc_f), .wrap(wrap_f), .ovf(ovf_f));

  typedef struct {
    logic       rst_n, en, up, sat, sclr, load;
    logic [3:0] d;
    logic [3:0] eq;
    logic       ew, eo, et;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic u,
                              input logic s, input logic c, input logic l,
                              input logic [3:0] dv, input logic [3:0] eq,
                              input logic ew, input logic eo, input logic et);
    vec_t v;
    v.rst_n = r; v.en = e; v.up = u; v.sat = s; v.sclr = c; v.load = l;
    v.d = dv; v.eq = eq; v.ew = ew; v.eo = eo; v.et = et;
    return v;
  endfunction

  task automatic check_out(input string name);
    logic [8:0] exp;
    logic [6:0] act;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    exp = exp_q.pop_front();
    case (exp[8:7])
      SEL_A:   act = {q_a, wrap_a, ovf_a, tc_a};
      SEL_P:   act = {q_p, wrap_p, ovf_p, tc_p};
      default: act = {q_f, wrap_f, ovf_f, tc_f};
    endcase
    checks++;
    if (act !== exp[6:0]) begin
      errors++;
      $display("FAIL %s: got q=%0d wrap=%b ovf=%b tc=%b, want q=%0d wrap=%b ovf=%b tc=%b",
               name, act[6:3], act[2], act[1], act[0],
               exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive at negedge, record expectation, sample 1 time unit after posedge.
  task automatic step(input logic [1:0] sel, input vec_t v, input string name);
    @(negedge clk);
    reset = v.rst_n; en = v.en; up = v.up; sat = v.sat;
    sclr = v.sclr; load = v.load; d = v.d;
    exp_q.push_back({sel, v.eq, v.ew, v.eo, v.et});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  vec_t tbl[30];

  initial begin
    //            rst en up sat clr ld d     q    w  o  tc
    tbl[0]  = mk(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) tbl[i] = mk(1, 1, 1, 0, 0, 0, 4'd0, 4'(i), 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    for (int i = 8; i <= 15; i++) tbl[i] = mk(1, 1, 1, 0, 0, 0, 4'd0, 4'(i-7), 0, 0, 0);
    tbl[16] = mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd9, 0, 0, 1);
    tbl[17] = mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0);
    tbl[18] = mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd1, 0, 1, 0);
    tbl[19] = mk(1, 1, 1, 0, 0, 1, 4'd13, 4'd9, 0, 0, 1);
    tbl[20] = mk(1, 1, 1, 0, 1, 1, 4'd5, 4'd0, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 1, 0, 1, 4'd2, 4'd2, 0, 0, 0);
    tbl[22] = mk(1, 1, 0, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0);
    tbl[23] = mk(1, 1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 1);
    tbl[24] = mk(1, 1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 1);
    tbl[25] = mk(1, 1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 1);
    tbl[26] = mk(1, 1, 0, 0, 0, 0, 4'd0, 4'd9, 1, 1, 0);
    tbl[27] = mk(1, 0, 0, 0, 0, 0, 4'd0, 4'd9, 0, 1, 0);
    tbl[28] = mk(1, 1, 1, 1, 0, 0, 4'd0, 4'd9, 0, 1, 1);
    tbl[29] = mk(1, 1, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0);

    for (int i = 0; i < 30; i++) step(SEL_A, tbl[i], $sformatf("mod10_vec%0d", i));

    // Prescaler /4: reset, then q advances on every 4th enabled cycle.
    step(SEL_P, mk(0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0), "pre_reset");
    for (int i = 0; i < 8; i++)
      step(SEL_P, mk(1, 1, 1, 0, 0, 0, 4'd0, 4'((i + 1) / 4), 0, 0, 0),
           $sformatf("pre_run%0d", i));
    // Two enabled, three idle, two enabled: the next tick lands 3 cycles late.
    for (int i = 0; i < 2; i++)
      step(SEL_P, mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd2, 0, 0, 0), "pre_gap_a");
    for (int i = 0; i < 3; i++)
      step(SEL_P, mk(1, 0, 1, 0, 0, 0, 4'd0, 4'd2, 0, 0, 0), "pre_gap_idle");
    step(SEL_P, mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd2, 0, 0, 0), "pre_gap_b");
    step(SEL_P, mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd3, 0, 0, 0), "pre_gap_tick");
    // Load mid-phase restarts the prescaler.
    step(SEL_P, mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd3, 0, 0, 0), "pre_phase1");
    step(SEL_P, mk(1, 1, 1, 0, 0, 1, 4'd5, 4'd5, 0, 0, 0), "pre_load");
    for (int i = 0; i < 3; i++)
      step(SEL_P, mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd5, 0, 0, 0), "pre_after_load");
    step(SEL_P, mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd6, 0, 0, 0), "pre_load_tick");

    // Full range MOD16: down-wrap from 0, then 15 ticks back to 0.
    step(SEL_F, mk(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0), "full_reset");
    step(SEL_F, mk(1, 1, 0, 0, 0, 0, 4'd0, 4'd15, 1, 1, 0), "full_wrap");
    for (int i = 14; i >= 0; i--)
      step(SEL_F, mk(1, 1, 0, 0, 0, 0, 4'd0, 4'(i), 0, 1, (i == 0)),
           $sformatf("full_down%0d", i));

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
